regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 127 ++++++++++++
 tb/tb_regfile_mp.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register pending (scoreboard) bit.
// Two combinational read ports with write-first bypass, two write ports
// (port 1 wins on address collision) and a set port that marks a register
// as awaiting a producer. Register 0 is hardwired to zero when ZERO_REG=1.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  output logic              pend_any
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_pend;

  logic [NREGS-1:0]  w_sel0;
  logic [NREGS-1:0]  w_sel1;
  logic [NREGS-1:0]  w_set;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_busy1;
  logic              w_busy2;

  // One-hot write/set decode; register 0 masked out when it is hardwired.
  always_comb begin : write_decode
    w_sel0 = '0;
    w_sel1 = '0;
    w_set  = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      w_sel0[i] = we0    && (wa0      == ADDR_W'(i));
      w_sel1[i] = we1    && (wa1      == ADDR_W'(i));
      w_set[i]  = set_en && (set_addr == ADDR_W'(i));
    end
    if (ZERO_REG) begin
      w_sel0[0] = 1'b0;
      w_sel1[0] = 1'b0;
      w_set[0]  = 1'b0;
    end
  end

  // Register array update; port 1 (long-latency path) overrides port 0.
  always_ff @(posedge clk or negedge rst_n) begin : reg_update
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (w_sel1[i]) begin
          r_regs[i] <= wd1;
        end else if (w_sel0[i]) begin
          r_regs[i] <= wd0;
        end
      end
    end
  end

  // Pending vector: writes retire a producer, a set issues a new one and wins.
  always_ff @(posedge clk or negedge rst_n) begin : pend_update
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~(w_sel0 | w_sel1)) | w_set;
    end
  end

  // Read port 1 with write-first bypass and zero-register override.
  always_comb begin : read_port1
    w_rd1   = r_regs[ra1];
    w_busy1 = r_pend[ra1];
    if (we0 && (wa0 == ra1)) begin
      w_rd1   = wd0;
      w_busy1 = 1'b0;
    end
    if (we1 && (wa1 == ra1)) begin
      w_rd1   = wd1;
      w_busy1 = 1'b0;
    end
    if (ZERO_REG && (ra1 == '0)) begin
      w_rd1   = '0;
      w_busy1 = 1'b0;
    end
  end

  // Read port 2 with write-first bypass and zero-register override.
  always_comb begin : read_port2
    w_rd2   = r_regs[ra2];
    w_busy2 = r_pend[ra2];
    if (we0 && (wa0 == ra2)) begin
      w_rd2   = wd0;
      w_busy2 = 1'b0;
    end
    if (we1 && (wa1 == ra2)) begin
      w_rd2   = wd1;
      w_busy2 = 1'b0;
    end
    if (ZERO_REG && (ra2 == '0)) begin
      w_rd2   = '0;
      w_busy2 = 1'b0;
    end
  end

  assign rd1      = w_rd1;
  assign rd2      = w_rd2;
  assign busy1    = w_busy1;
  assign busy2    = w_busy2;
  assign pend_any = |r_pend;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expectations are queued as stimulus is
// driven and drained once the combinational outputs have settled.
module tb_regfile_mp;

  localparam int S_RD1 = 0, S_RD2 = 1, S_BUSY1 = 2, S_BUSY2 = 3, S_PEND = 4;
  localparam int S_XRD1 = 5, S_XRD2 = 6, S_XBUSY2 = 7, S_XPEND = 8;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa0, wa1, set_addr;
  logic [31:0] rd1, rd2, wd0, wd1;
  logic        busy1, busy2, we0, we1, set_en, pend_any;

  logic [2:0]  x_ra1, x_ra2, x_wa0, x_wa1, x_set_addr;
  logic [63:0] x_rd1, x_rd2, x_wd0, x_wd1;
  logic        x_busy1, x_busy2, x_we0, x_we1, x_set_en, x_pend_any;

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_mp u_dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .set_en(set_en), .set_addr(set_addr),
    .pend_any(pend_any)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(1'b0)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .ra1(x_ra1), .ra2(x_ra2), .rd1(x_rd1), .rd2(x_rd2),
    .busy1(x_busy1), .busy2(x_busy2), .we0(x_we0), .wa0(x_wa0), .wd0(x_wd0),
    .we1(x_we1), .wa1(x_wa1), .wd1(x_wd1), .set_en(x_set_en),
    .set_addr(x_set_addr), .pend_any(x_pend_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it mismatches.
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] get_act(input int sel);
    case (sel)
      S_RD1:    return 64'(rd1);
      S_RD2:    return 64'(rd2);
      S_BUSY1:  return 64'(busy1);
      S_BUSY2:  return 64'(busy2);
      S_PEND:   return 64'(pend_any);
      S_XRD1:   return x_rd1;
      S_XRD2:   return x_rd2;
      S_XBUSY2: return 64'(x_busy2);
      S_XPEND:  return 64'(x_pend_any);
      default:  return 'x;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Let outputs settle, then compare every queued expectation.
  task automatic drain();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, get_act(e.sel), e.val);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return m_pend[a] && !(we1 && wa1 == a) && !(we0 && wa0 == a);
  endfunction

  task automatic push_model(input string tag);
    push({tag, "_rd1"},   S_RD1,   64'(exp_rd(ra1)));
    push({tag, "_rd2"},   S_RD2,   64'(exp_rd(ra2)));
    push({tag, "_busy1"}, S_BUSY1, 64'(exp_busy(ra1)));
    push({tag, "_busy2"}, S_BUSY2, 64'(exp_busy(ra2)));
    push({tag, "_pend"},  S_PEND,  64'(m_pend != 32'd0));
  endtask

  task automatic idle();
    we0 = 0; wa0 = '0; wd0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0;
    set_en = 0; set_addr = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pend = '0;
  endtask

  // Advance the reference model with the current inputs, then one clock.
  task automatic tick();
    if (we0 && wa0 != 5'd0) m_regs[wa0] = wd0;
    if (we1 && wa1 != 5'd0) m_regs[wa1] = wd1;
    if (we0) m_pend[wa0] = 1'b0;
    if (we1) m_pend[wa1] = 1'b0;
    if (set_en) m_pend[set_addr] = 1'b1;
    m_pend[0] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] v64(input int a);
    return {32'hC0DE0000 + 32'(a), ~32'(a)};
  endfunction

  initial begin
    rst_n = 0;
    idle();
    ra1 = 5'd3; ra2 = 5'd17;
    x_ra1 = '0; x_ra2 = '0; x_we0 = 0; x_wa0 = '0; x_wd0 = '0;
    x_we1 = 0; x_wa1 = '0; x_wd1 = '0; x_set_en = 0; x_set_addr = '0;
    model_reset();

    // Reset state.
    @(posedge clk); #1;
    push("rst_rd1", S_RD1, 0); push("rst_rd2", S_RD2, 0);
    push("rst_busy1", S_BUSY1, 0); push("rst_busy2", S_BUSY2, 0);
    push("rst_pend", S_PEND, 0);
    drain();
    rst_n = 1;
    tick();

    // Dual write collision: port 1 wins, in bypass and in storage.
    we0 = 1; wa0 = 5'd7; wd0 = 32'h11111111;
    we1 = 1; wa1 = 5'd7; wd1 = 32'h22222222; ra1 = 5'd7;
    push("coll_bypass", S_RD1, 64'h22222222);
    drain();
    tick();
    idle(); ra2 = 5'd7;
    push("coll_stored", S_RD2, 64'h22222222);
    drain();

    // Zero register ignores writes and sets.
    we0 = 1; wa0 = 5'd0; wd0 = 32'hDEADBEEF; set_en = 1; set_addr = 5'd0; ra1 = 5'd0;
    push("zero_rd_byp", S_RD1, 0); push("zero_busy_byp", S_BUSY1, 0);
    push("zero_pend0", S_PEND, 0);
    drain();
    tick();
    idle();
    push("zero_rd", S_RD1, 0); push("zero_busy", S_BUSY1, 0);
    push("zero_pend1", S_PEND, 0);
    drain();

    // Scoreboard lifecycle on register 5.
    set_en = 1; set_addr = 5'd5; ra1 = 5'd5;
    push("life_busy_pre", S_BUSY1, 0);
    drain();
    tick();
    idle();
    push("life_busy", S_BUSY1, 1); push("life_pend", S_PEND, 1);
    drain();
    we1 = 1; wa1 = 5'd5; wd1 = 32'hA5;
    push("life_busy_byp", S_BUSY1, 0); push("life_rd_byp", S_RD1, 64'hA5);
    push("life_pend_reg", S_PEND, 1);
    drain();
    tick();
    idle();
    push("life_busy_post", S_BUSY1, 0); push("life_pend_post", S_PEND, 0);
    push("life_rd_post", S_RD1, 64'hA5);
    drain();

    // Set and write to the same register: set wins.
    set_en = 1; set_addr = 5'd9; we0 = 1; wa0 = 5'd9; wd0 = 32'd3; ra2 = 5'd9;
    push("sw_rd_byp", S_RD2, 3); push("sw_busy_byp", S_BUSY2, 0);
    drain();
    tick();
    idle(); ra1 = 5'd9;
    push("sw_rd1", S_RD1, 3); push("sw_busy1", S_BUSY1, 1);
    push("sw_busy2", S_BUSY2, 1); push("sw_pend", S_PEND, 1);
    drain();
    we0 = 1; wa0 = 5'd9; wd0 = 32'd3;
    tick();
    idle();

    // Random traffic on a narrow address window, checked against the model.
    for (int c = 0; c < 60; c++) begin
      we0 = ($urandom_range(0, 1) == 1); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom;
      we1 = ($urandom_range(0, 2) == 0); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom;
      set_en = ($urandom_range(0, 2) == 0); set_addr = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7)); ra2 = 5'($urandom_range(0, 7));
      push_model("rnd");
      drain();
      tick();
    end
    idle();

    // Fill registers 1..31, mark 4 pending, then reset mid-cycle.
    for (int a = 1; a < 32; a++) begin
      we0 = 1; wa0 = 5'(a); wd0 = 32'h10000000 | 32'(a);
      tick();
    end
    idle(); set_en = 1; set_addr = 5'd4;
    tick();
    idle(); ra1 = 5'd4; ra2 = 5'd31;
    push("pre_rst_rd", S_RD1, 64'h10000004); push("pre_rst_busy", S_BUSY1, 1);
    push("pre_rst_rd2", S_RD2, 64'h1000001F);
    drain();
    rst_n = 0;
    model_reset();
    push("arst_busy1", S_BUSY1, 0); push("arst_pend", S_PEND, 0);
    push("arst_rd1", S_RD1, 0);
    drain();
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      push("arst_rd1", S_RD1, 0); push("arst_rd2", S_RD2, 0);
      push("arst_busy2", S_BUSY2, 0);
      drain();
    end
    // Writes and sets during reset must be dropped.
    we0 = 1; wa0 = 5'd6; wd0 = 32'h55; set_en = 1; set_addr = 5'd6;
    @(posedge clk); @(posedge clk); #1;
    idle();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    ra1 = 5'd6; ra2 = 5'd4;
    push("post_rst_rd", S_RD1, 0); push("post_rst_busy", S_BUSY1, 0);
    push("post_rst_pend", S_PEND, 0); push("post_rst_rd2", S_RD2, 0);
    drain();
    we1 = 1; wa1 = 5'd3; wd1 = 32'hCAFEF00D;
    tick();
    idle(); ra1 = 5'd3;
    push("post_rst_wr", S_RD1, 64'hCAFEF00D);
    drain();

    // 64-bit / 8-register instance without a zero register.
    x_we0 = 1; x_wa0 = 3'd0; x_wd0 = 64'hFFFFFFFF00000001;
    tick();
    x_we0 = 0; x_ra2 = 3'd0;
    push("w64_reg0", S_XRD2, 64'hFFFFFFFF00000001);
    drain();
    x_set_en = 1; x_set_addr = 3'd0;
    tick();
    x_set_en = 0;
    push("w64_busy0", S_XBUSY2, 1); push("w64_pend", S_XPEND, 1);
    drain();
    for (int a = 0; a < 8; a++) begin
      x_we1 = 1; x_wa1 = 3'(a); x_wd1 = v64(a);
      tick();
    end
    x_we1 = 0;
    push("w64_pend_clr", S_XPEND, 0);
    drain();
    for (int a = 0; a < 8; a++) begin
      x_ra1 = 3'(a); x_ra2 = 3'(7 - a);
      push("w64_rd1", S_XRD1, v64(a)); push("w64_rd2", S_XRD2, v64(7 - a));
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
